tt_response_checker: RTL and testbench

//  Hardware response end of the exhaustive truth-table sweep.
//  - Drives every N_IN-bit input vector, 0 .. 2**N_IN-1, to a combinational DUT.
//  - Samples the DUT's 1-bit response for each vector and builds the captured truth table.
//  - Compares the table bit-by-bit against EXPECTED and reports pass/fail, mismatch count and first failing index.
//  - Replaces the manual waveform check in lab self-test tops.

---
 rtl/tt_response_checker_pkg.sv | 22 ++
 rtl/tt_response_checker.sv | 139 +++++++++++++
 tb/tb_tt_response_checker.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/tt_response_checker_pkg.sv
// Shared types and defaults for the exhaustive truth-table response checker.
// Holds the FSM state encoding and the default sweep parameters.
package tt_response_checker_pkg;

  localparam int unsigned DEF_N_IN   = 4;
  localparam int unsigned DEF_SETTLE = 1;
  localparam logic [15:0] DEF_EXPECTED = 16'h6996;

  // Encodings are fixed so the state can be probed from lab self-test tops.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Width of a counter that must hold values 0 .. max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/tt_response_checker.sv
// Sweeps every N_IN-bit vector into a combinational DUT, captures its 1-bit
// response per vector and compares the resulting truth table to EXPECTED.
module tt_response_checker
  import tt_response_checker_pkg::*;
#(
  parameter int unsigned         N_IN     = DEF_N_IN,
  parameter logic [2**N_IN-1:0]  EXPECTED = DEF_EXPECTED,
  parameter int unsigned         SETTLE   = DEF_SETTLE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [N_IN-1:0]    stim,
  input  logic               resp,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2**N_IN-1:0] captured,
  output logic [N_IN:0]      fail_cnt,
  output logic [N_IN-1:0]    fail_idx,
  output logic               fail_valid
);

  localparam int unsigned N_VEC  = 2**N_IN;
  localparam int unsigned WCNT_W = cnt_width(SETTLE);

  localparam logic [N_IN-1:0]   LAST_IDX    = N_IN'(N_VEC - 1);
  localparam logic [WCNT_W-1:0] SETTLE_LAST = WCNT_W'(SETTLE - 1);

  state_t             state_q,      state_d;
  logic [N_IN-1:0]    idx_q,        idx_d;
  logic [WCNT_W-1:0]  wcnt_q,       wcnt_d;
  logic [N_VEC-1:0]   captured_q,   captured_d;
  logic [N_IN:0]      fail_cnt_q,   fail_cnt_d;
  logic [N_IN-1:0]    fail_idx_q,   fail_idx_d;
  logic               fail_valid_q, fail_valid_d;
  logic               pass_q,       pass_d;
  logic               mismatch;

  assign mismatch = (resp != EXPECTED[idx_q]);

  // NOTE: every variable gets its hold value before the case statement, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    wcnt_d       = wcnt_q;
    captured_d   = captured_q;
    fail_cnt_d   = fail_cnt_q;
    fail_idx_d   = fail_idx_q;
    fail_valid_d = fail_valid_q;
    pass_d       = pass_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_APPLY;
          idx_d        = '0;
          wcnt_d       = '0;
          captured_d   = '0;
          fail_cnt_d   = '0;
          fail_idx_d   = '0;
          fail_valid_d = 1'b0;
          pass_d       = 1'b0;
        end
      end

      ST_APPLY: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == SETTLE_LAST) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        captured_d[idx_q] = resp;
        if (mismatch) begin
          fail_cnt_d = fail_cnt_q + 1'b1;
          if (!fail_valid_q) begin
            fail_idx_d   = idx_q;
            fail_valid_d = 1'b1;
          end
        end
        // Terminate on the last index rather than letting idx wrap to 0.
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          pass_d  = (fail_cnt_d == '0);
        end else begin
          state_d = ST_APPLY;
          idx_d   = idx_q + 1'b1;
          wcnt_d  = '0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      wcnt_q       <= '0;
      captured_q   <= '0;
      fail_cnt_q   <= '0;
      fail_idx_q   <= '0;
      fail_valid_q <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      wcnt_q       <= wcnt_d;
      captured_q   <= captured_d;
      fail_cnt_q   <= fail_cnt_d;
      fail_idx_q   <= fail_idx_d;
      fail_valid_q <= fail_valid_d;
      pass_q       <= pass_d;
    end
  end

  // The DUT only sees the sweep index while a vector is being applied.
  assign stim       = (state_q == ST_APPLY || state_q == ST_SAMPLE) ? idx_q : '0;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign captured   = captured_q;
  assign fail_cnt   = fail_cnt_q;
  assign fail_idx   = fail_idx_q;
  assign fail_valid = fail_valid_q;

endmodule

// File: tb/tb_tt_response_checker.sv
// Directed bench for tt_response_checker with a behavioural lab DUT whose
// response function is selected per scenario.
module tb_tt_response_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  stim;
  logic        resp;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] captured;
  logic [4:0]  fail_cnt;
  logic [3:0]  fail_idx;
  logic        fail_valid;

  int tests = 0;
  int fails = 0;
  int mode  = 0;  // 0 parity, 1 stuck-0, 2 inverted parity, 3 parity with vector 13 flipped

  always #5 clk = ~clk;

  always_comb begin
    case (mode)
      1:       resp = 1'b0;
      2:       resp = ~^stim;
      3:       resp = (^stim) ^ (stim == 4'd13);
      default: resp = ^stim;
    endcase
  end

  tt_response_checker #(
    .N_IN(4), .EXPECTED(16'h6996), .SETTLE(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stim(stim), .resp(resp),
    .busy(busy), .done(done), .pass(pass), .captured(captured),
    .fail_cnt(fail_cnt), .fail_idx(fail_idx), .fail_valid(fail_valid)
  );

  // Pulses start and counts rising edges (including the one that samples
  // start) until done is seen high. restart_at >= 0 re-pulses start when
  // stim shows that value mid-sweep.
  task automatic run_sweep(input int restart_at, output int cycles, output bit done_seen);
    bit repulsed = 0;
    done_seen = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    cycles = 1;
    #1 start = 1'b0;
    while (cycles < 200) begin
      @(negedge clk);
      if (done) begin
        done_seen = 1;
        break;
      end
      if (restart_at >= 0 && !repulsed && int'(stim) == restart_at && busy) begin
        start = 1'b1;
        repulsed = 1;
      end
      @(posedge clk);
      cycles++;
      #1 start = 1'b0;
    end
    tests++;
    if (!done_seen) begin
      fails++;
      $display("FAIL sweep_timeout: done not seen after %0d cycles, required within 33", cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({stim, busy, done, pass, captured, fail_cnt, fail_idx, fail_valid} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: stim=%h busy=%b done=%b pass=%b cap=%h cnt=%0d idx=%0d fv=%b, required all 0",
               stim, busy, done, pass, captured, fail_cnt, fail_idx, fail_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_sweep(input string name, input int m, input int restart_at,
                            input logic [15:0] exp_cap, input logic exp_pass,
                            input logic [4:0] exp_cnt, input logic [3:0] exp_idx,
                            input logic exp_fv);
    int cycles;
    bit seen;
    mode = m;
    run_sweep(restart_at, cycles, seen);
    tests++;
    if (cycles !== 33) begin
      fails++;
      $display("FAIL %s_latency: done after %0d cycles, required 33", name, cycles);
    end
    tests++;
    if (captured !== exp_cap) begin
      fails++;
      $display("FAIL %s_captured: got %h, required %h", name, captured, exp_cap);
    end
    tests++;
    if (pass !== exp_pass) begin
      fails++;
      $display("FAIL %s_pass: got %b, required %b", name, pass, exp_pass);
    end
    tests++;
    if (fail_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL %s_fail_cnt: got %0d, required %0d", name, fail_cnt, exp_cnt);
    end
    tests++;
    if (fail_valid !== exp_fv) begin
      fails++;
      $display("FAIL %s_fail_valid: got %b, required %b", name, fail_valid, exp_fv);
    end
    if (exp_fv) begin
      tests++;
      if (fail_idx !== exp_idx) begin
        fails++;
        $display("FAIL %s_fail_idx: got %0d, required %0d", name, fail_idx, exp_idx);
      end
    end
  endtask

  // Start coincident with DONE is ignored; results hold in IDLE with stim=0.
  task automatic test_back_to_back();
    int cycles;
    bit seen;
    mode = 0;
    run_sweep(-1, cycles, seen);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL start_in_done: busy=%b done=%b, required 0 0", busy, done);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (stim !== 4'd0 || captured !== 16'h6996 || pass !== 1'b1) begin
      fails++;
      $display("FAIL idle_hold: stim=%h cap=%h pass=%b, required 0 6996 1", stim, captured, pass);
    end
  endtask

  task automatic test_mid_sweep_reset();
    int guard = 0;
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    while (stim !== 4'd5 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (stim !== 4'd5) begin
      fails++;
      $display("FAIL reach_stim5: stim=%h, required 5", stim);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({stim, busy, done, pass, captured, fail_cnt, fail_idx, fail_valid} !== '0) begin
      fails++;
      $display("FAIL midsweep_reset: stim=%h busy=%b cap=%h cnt=%0d fv=%b, required all 0",
               stim, busy, captured, fail_cnt, fail_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_sweep("parity",   0, -1, 16'h6996, 1'b1, 5'd0,  4'd0,  1'b0);
    test_sweep("stuck0",   1, -1, 16'h0000, 1'b0, 5'd8,  4'd1,  1'b1);
    test_sweep("inverted", 2, -1, 16'h9669, 1'b0, 5'd16, 4'd0,  1'b1);
    test_sweep("flip13",   3, -1, 16'h4996, 1'b0, 5'd1,  4'd13, 1'b1);
    test_sweep("restart7", 0, 7,  16'h6996, 1'b1, 5'd0,  4'd0,  1'b0);
    test_back_to_back();
    test_mid_sweep_reset();
    test_sweep("after_rst", 0, -1, 16'h6996, 1'b1, 5'd0, 4'd0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
